id_ex_issue: RTL and testbench

- Pipeline register between Decode and Execute; the producing end of the ALU operand/control interface.
- Each cycle it captures one decoded instruction bundle and translates `alu_op`/`funct`/`opcode` into the 3-bit ALU control code.
- It selects and extends operand B and registers everything for the ALU and the EX/MEM stage.
- It implements pipeline hold (stall) and bubble insertion (flush), and flags unsupported encodings.

---
 rtl/mips_pkg.sv | 32 +++
 rtl/id_ex_issue_if.sv | 27 ++
 rtl/id_ex_issue_alu_ctrl_decode.sv | 51 +++++
 rtl/id_ex_issue.sv | 76 +++++++
 tb/tb_id_ex_issue.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encodings: ALU control codes, alu_op classes and the
// funct/opcode values the ID/EX issue stage understands.
package mips_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_RTYPE = 2'b10,
    ALU_OP_ITYPE = 2'b11
  } alu_op_e;

  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_SUBU = 6'b100011;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;

  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

endpackage

// File: rtl/id_ex_issue_if.sv
// ALU operand/control bundle leaving the ID/EX register; the issue stage
// drives it through the master modport, the ALU and EX/MEM read the slave.
interface id_ex_issue_if #(parameter int XLEN = 32);

  logic            ex_valid;
  logic [XLEN-1:0] ex_a;
  logic [XLEN-1:0] ex_b;
  logic [XLEN-1:0] ex_store_data;
  logic [2:0]      ex_alu_control;
  logic [4:0]      ex_dest_reg;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            ex_mem_to_reg;
  logic            ex_illegal;

  modport master (
    output ex_valid, ex_a, ex_b, ex_store_data, ex_alu_control, ex_dest_reg,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal
  );

  modport slave (
    input ex_valid, ex_a, ex_b, ex_store_data, ex_alu_control, ex_dest_reg,
          ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal
  );

endinterface

// File: rtl/id_ex_issue_alu_ctrl_decode.sv
// Combinational translation of alu_op/funct/opcode into the 3-bit ALU code,
// the immediate extension kind and an unsupported-encoding flag.
module alu_ctrl_decode
  import mips_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  input  logic [5:0] opcode,
  output logic [2:0] alu_control,
  output logic       zero_ext,
  output logic       illegal
);

  always_comb begin
    alu_control = ALU_ADD;
    zero_ext    = 1'b0;
    illegal     = 1'b0;
    case (alu_op_e'(alu_op))
      ALU_OP_ADD: alu_control = ALU_ADD;
      ALU_OP_SUB: alu_control = ALU_SUB;
      ALU_OP_RTYPE: begin
        case (funct)
          FUNCT_ADD, FUNCT_ADDU: alu_control = ALU_ADD;
          FUNCT_SUB, FUNCT_SUBU: alu_control = ALU_SUB;
          FUNCT_AND:             alu_control = ALU_AND;
          FUNCT_OR:              alu_control = ALU_OR;
          FUNCT_SLT:             alu_control = ALU_SLT;
          default:               illegal     = 1'b1;
        endcase
      end
      ALU_OP_ITYPE: begin
        // Only the logical immediates zero-extend; arithmetic and slti sign-extend.
        case (opcode)
          OP_ADDI, OP_ADDIU: alu_control = ALU_ADD;
          OP_SLTI:           alu_control = ALU_SLT;
          OP_ANDI: begin
            alu_control = ALU_AND;
            zero_ext    = 1'b1;
          end
          OP_ORI: begin
            alu_control = ALU_OR;
            zero_ext    = 1'b1;
          end
          default:           illegal     = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_issue.sv
// ID/EX pipeline register: decodes the ALU control, builds operand B and
// registers the bundle with reset > flush > stall > load priority.
module id_ex_issue
  import mips_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  input  logic [5:0]        opcode,
  input  logic              alu_src,
  input  logic [XLEN-1:0]   rd1,
  input  logic [XLEN-1:0]   rd2,
  input  logic [15:0]       imm16,
  input  logic [4:0]        dest_reg,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_to_reg,
  id_ex_issue_if.master     ex
);

  logic [2:0]      dec_control;
  logic            dec_zero_ext;
  logic            dec_illegal;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] operand_b;

  alu_ctrl_decode u_decode (
    .alu_op      (alu_op),
    .funct       (funct),
    .opcode      (opcode),
    .alu_control (dec_control),
    .zero_ext    (dec_zero_ext),
    .illegal     (dec_illegal)
  );

  assign imm_ext   = dec_zero_ext ? {{(XLEN-16){1'b0}}, imm16}
                                  : {{(XLEN-16){imm16[15]}}, imm16};
  assign operand_b = alu_src ? imm_ext : rd2;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      ex.ex_valid       <= 1'b0;
      ex.ex_a           <= '0;
      ex.ex_b           <= '0;
      ex.ex_store_data  <= '0;
      ex.ex_alu_control <= ALU_ADD;
      ex.ex_dest_reg    <= '0;
      ex.ex_reg_write   <= 1'b0;
      ex.ex_mem_read    <= 1'b0;
      ex.ex_mem_write   <= 1'b0;
      ex.ex_mem_to_reg  <= 1'b0;
      ex.ex_illegal     <= 1'b0;
    end else if (!stall) begin
      // Data fields load even for bubbles; only control is suppressed.
      ex.ex_a           <= rd1;
      ex.ex_b           <= operand_b;
      ex.ex_store_data  <= rd2;
      ex.ex_dest_reg    <= dest_reg;
      ex.ex_valid       <= in_valid;
      ex.ex_illegal     <= in_valid && dec_illegal;
      ex.ex_alu_control <= (in_valid && !dec_illegal) ? dec_control : ALU_ADD;
      ex.ex_reg_write   <= in_valid && !dec_illegal && reg_write;
      ex.ex_mem_read    <= in_valid && !dec_illegal && mem_read;
      ex.ex_mem_write   <= in_valid && !dec_illegal && mem_write;
      ex.ex_mem_to_reg  <= in_valid && mem_to_reg;
    end
  end

endmodule

// File: tb/tb_id_ex_issue.sv
// Self-checking bench for id_ex_issue: directed scenarios followed by random
// traffic, all compared against a table-driven model of the stage.
module tb_id_ex_issue;

  localparam int XLEN = 32;

  logic              clk = 1'b0;
  logic              reset, stall, flush, in_valid, alu_src;
  logic [1:0]        alu_op;
  logic [5:0]        funct, opcode;
  logic [XLEN-1:0]   rd1, rd2;
  logic [15:0]       imm16;
  logic [4:0]        dest_reg;
  logic              reg_write, mem_read, mem_write, mem_to_reg;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] code;
    logic       zext;
    logic       illegal;
  } dec_t;

  // Expected register contents; b_known drops when B's extension is unspecified.
  logic            m_valid, m_illegal, m_rw, m_mr, m_mw, m_mtr, m_b_known;
  logic [31:0]     m_a, m_b, m_sd;
  logic [2:0]      m_ctl;
  logic [4:0]      m_dest;

  id_ex_issue_if #(.XLEN(XLEN)) ex_bus ();

  id_ex_issue #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .in_valid   (in_valid),
    .alu_op     (alu_op),
    .funct      (funct),
    .opcode     (opcode),
    .alu_src    (alu_src),
    .rd1        (rd1),
    .rd2        (rd2),
    .imm16      (imm16),
    .dest_reg   (dest_reg),
    .reg_write  (reg_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .ex         (ex_bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic dec_t refDecode(input logic [1:0] op, input logic [5:0] f,
                                     input logic [5:0] o);
    dec_t d;
    d = '{code: 3'b010, zext: 1'b0, illegal: 1'b0};
    if (op == 2'b01) d.code = 3'b110;
    else if (op == 2'b10) begin
      case (f)
        6'h20, 6'h21: d.code = 3'b010;
        6'h22, 6'h23: d.code = 3'b110;
        6'h24:        d.code = 3'b000;
        6'h25:        d.code = 3'b001;
        6'h2a:        d.code = 3'b111;
        default:      d.illegal = 1'b1;
      endcase
    end else if (op == 2'b11) begin
      case (o)
        6'h08, 6'h09: d.code = 3'b010;
        6'h0a:        d.code = 3'b111;
        6'h0c:        begin d.code = 3'b000; d.zext = 1'b1; end
        6'h0d:        begin d.code = 3'b001; d.zext = 1'b1; end
        default:      d.illegal = 1'b1;
      endcase
    end
    return d;
  endfunction

  task automatic clearModel();
    m_valid = 0; m_illegal = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_mtr = 0;
    m_a = 0; m_b = 0; m_sd = 0; m_ctl = 3'b010; m_dest = 0; m_b_known = 1;
  endtask

  task automatic updateModel();
    dec_t d;
    logic [31:0] ext;
    if (reset || flush) clearModel();
    else if (!stall) begin
      d   = refDecode(alu_op, funct, opcode);
      ext = d.zext ? {16'h0000, imm16} : {{16{imm16[15]}}, imm16};
      m_a = rd1; m_sd = rd2; m_dest = dest_reg;
      m_b = alu_src ? ext : rd2;
      m_b_known = !(d.illegal && alu_src);
      if (!in_valid) begin
        m_valid = 0; m_illegal = 0; m_ctl = 3'b010;
        m_rw = 0; m_mr = 0; m_mw = 0; m_mtr = 0;
      end else if (d.illegal) begin
        m_valid = 1; m_illegal = 1; m_ctl = 3'b010;
        m_rw = 0; m_mr = 0; m_mw = 0; m_mtr = mem_to_reg;
      end else begin
        m_valid = 1; m_illegal = 0; m_ctl = d.code;
        m_rw = reg_write; m_mr = mem_read; m_mw = mem_write; m_mtr = mem_to_reg;
      end
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".valid"},   32'(ex_bus.ex_valid),       32'(m_valid));
    checkOutput({tag, ".illegal"}, 32'(ex_bus.ex_illegal),     32'(m_illegal));
    checkOutput({tag, ".ctl"},     32'(ex_bus.ex_alu_control), 32'(m_ctl));
    checkOutput({tag, ".a"},       ex_bus.ex_a,                m_a);
    if (m_b_known) checkOutput({tag, ".b"}, ex_bus.ex_b, m_b);
    checkOutput({tag, ".sd"},      ex_bus.ex_store_data,       m_sd);
    checkOutput({tag, ".dest"},    32'(ex_bus.ex_dest_reg),    32'(m_dest));
    checkOutput({tag, ".rw"},      32'(ex_bus.ex_reg_write),   32'(m_rw));
    checkOutput({tag, ".mr"},      32'(ex_bus.ex_mem_read),    32'(m_mr));
    checkOutput({tag, ".mw"},      32'(ex_bus.ex_mem_write),   32'(m_mw));
    checkOutput({tag, ".mtr"},     32'(ex_bus.ex_mem_to_reg),  32'(m_mtr));
  endtask

  // Inputs are set before calling; the model samples them on the same edge as the DUT.
  task automatic applyStimulus(input string tag);
    @(posedge clk);
    updateModel();
    #1;
    checkAll(tag);
  endtask

  task automatic randomData();
    rd1 = $urandom; rd2 = $urandom; imm16 = 16'($urandom);
    dest_reg = 5'($urandom); alu_src = 1'($urandom);
    reg_write = 1'($urandom); mem_read = 1'($urandom);
    mem_write = 1'($urandom); mem_to_reg = 1'($urandom);
    alu_op = 2'($urandom); funct = 6'($urandom); opcode = 6'($urandom);
  endtask

  task automatic plainValid();
    reset = 0; stall = 0; flush = 0; in_valid = 1;
    reg_write = 1; mem_read = 0; mem_write = 0; mem_to_reg = 0;
    alu_src = 0; dest_reg = 5'd9; imm16 = 16'h0; opcode = 6'h0; funct = 6'h20;
  endtask

  initial begin
    logic [5:0] functs [7];
    logic [5:0] opcodes [5];
    functs  = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2a};
    opcodes = '{6'h08, 6'h09, 6'h0a, 6'h0c, 6'h0d};
    clearModel();

    stall = 0; flush = 0; in_valid = 1; reset = 1;
    randomData();
    applyStimulus("reset0");
    randomData(); stall = 1;
    applyStimulus("reset1");
    checkOutput("reset_ctl", 32'(ex_bus.ex_alu_control), 32'h2);

    plainValid(); alu_op = 2'b10; funct = 6'h22; rd1 = 7; rd2 = 3;
    applyStimulus("rsub");
    checkOutput("rsub_ctl", 32'(ex_bus.ex_alu_control), 32'h6);
    checkOutput("rsub_b", ex_bus.ex_b, 32'd3);

    plainValid(); alu_op = 2'b11; opcode = 6'h0c; imm16 = 16'hFFFF; alu_src = 1;
    applyStimulus("andi");
    checkOutput("andi_b", ex_bus.ex_b, 32'h0000FFFF);
    opcode = 6'h08;
    applyStimulus("addi");
    checkOutput("addi_b", ex_bus.ex_b, 32'hFFFFFFFF);

    plainValid(); alu_op = 2'b00; rd1 = 32'h100; imm16 = 16'h4; alu_src = 1;
    applyStimulus("ld_add");
    for (int i = 0; i < 3; i++) begin
      randomData(); stall = 1;
      applyStimulus("stall");
    end
    checkOutput("stall_a", ex_bus.ex_a, 32'h100);
    stall = 1; flush = 1; in_valid = 1; reg_write = 1;
    applyStimulus("flush_stall");
    checkOutput("flush_valid", 32'(ex_bus.ex_valid), 32'h0);

    plainValid(); alu_op = 2'b10; funct = 6'h00; reg_write = 1; mem_write = 1;
    applyStimulus("illegal");
    checkOutput("illegal_flag", 32'(ex_bus.ex_illegal), 32'h1);

    plainValid(); alu_op = 2'b00; imm16 = 16'h8000; alu_src = 1; mem_read = 1;
    applyStimulus("b2b_lw");
    checkOutput("b2b_lw_b", ex_bus.ex_b, 32'hFFFF8000);
    plainValid(); alu_op = 2'b01;
    applyStimulus("b2b_beq");
    plainValid(); alu_op = 2'b10; funct = 6'h25;
    applyStimulus("b2b_or");
    checkOutput("b2b_or_ctl", 32'(ex_bus.ex_alu_control), 32'h1);

    for (int i = 0; i < 600; i++) begin
      randomData();
      if ($urandom_range(0, 9) < 8) funct = functs[$urandom_range(0, 6)];
      if ($urandom_range(0, 9) < 8) opcode = opcodes[$urandom_range(0, 4)];
      reset    = ($urandom_range(0, 99) < 3);
      flush    = ($urandom_range(0, 99) < 10);
      stall    = ($urandom_range(0, 99) < 20);
      in_valid = ($urandom_range(0, 99) < 85);
      applyStimulus("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
